// File: rtl/pipe_stage_latch_pkg.sv
// Shared types and helpers for the inter-stage pipeline latch.
package pipe_latch_pkg;

   typedef enum logic [1:0] {EMPTY, ONE, FULL} st_t;

   localparam logic [31:0] DEF_NOP_INSN = 32'h0;
   localparam int MAX_PAY_W = 1024;

   // Payload of a bubble: NOP in the instruction field, zero elsewhere.
   function automatic logic [MAX_PAY_W-1:0] mkBubble(input int dataW, input int insField,
                                                     input logic [63:0] nop);
      logic [MAX_PAY_W-1:0] mask;
      logic [MAX_PAY_W-1:0] w;
      mask = (MAX_PAY_W'(1) << dataW) - MAX_PAY_W'(1);
      w    = MAX_PAY_W'(nop) & mask;
      return w << (insField * dataW);
   endfunction

endpackage

// File: rtl/pipe_stage_latch_if.sv
// Valid/ready payload channel between pipeline stages.
interface pipe_stage_latch_if #(
   parameter int DATA_W     = 32,
   parameter int NUM_FIELDS = 3,
   parameter int FLAG_W     = 1
);
   localparam int PAY_W = DATA_W * NUM_FIELDS;

   logic             valid;
   logic             ready;
   logic [PAY_W-1:0] data;
   logic [FLAG_W-1:0] flags;

   modport master (output valid, output data, output flags, input ready);
   modport slave  (input valid, input data, input flags, output ready);
endinterface

// File: rtl/pipe_stage_latch_reg.sv
// One latch entry: valid + payload + flags with load enable and sync clear-to-bubble.
module pipe_latch_reg #(
   parameter int PAY_W  = 96,
   parameter int FLAG_W = 1,
   parameter logic [PAY_W-1:0] BUBBLE = '0
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              ld,
   input  logic              vIn,
   input  logic [PAY_W-1:0]  dIn,
   input  logic [FLAG_W-1:0] fIn,
   output logic              vOut,
   output logic [PAY_W-1:0]  dOut,
   output logic [FLAG_W-1:0] fOut
);

   always_ff @(posedge clk) begin
      if (clr) begin
         vOut <= 1'b0;
         dOut <= BUBBLE;
         fOut <= '0;
      end else if (ld) begin
         vOut <= vIn;
         dOut <= dIn;
         fOut <= fIn;
      end
   end

endmodule

// File: rtl/pipe_stage_latch.sv
// Inter-stage pipeline register with valid/ready, 2-entry skid buffer and flush-to-bubble.
// Optional statistics counters enabled by defining PIPE_LATCH_STATS_EN.
module pipe_stage_latch
   import pipe_latch_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int NUM_FIELDS = 3,
   parameter int INS_FIELD  = 2,
   parameter int FLAG_W     = 1,
   parameter logic [DATA_W-1:0] NOP_INSN = DATA_W'(DEF_NOP_INSN),
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   pipe_stage_latch_if.slave  up,
   pipe_stage_latch_if.master dn,
   output logic [CNT_W-1:0] stat_stall_cnt,
   output logic [CNT_W-1:0] stat_flush_cnt
);

   localparam int PAY_W = DATA_W * NUM_FIELDS;
   localparam logic [PAY_W-1:0] BUBBLE = PAY_W'(mkBubble(DATA_W, INS_FIELD, 64'(NOP_INSN)));

   st_t st, stNext;
   logic clr, inFire;
   logic mainLd, mainVIn, mainV;
   logic skidLd, skidVIn, skidV;
   logic [PAY_W-1:0]  mainDIn, mainD, skidDIn, skidD;
   logic [FLAG_W-1:0] mainFIn, mainF, skidFIn, skidF;

   assign clr      = !rst_n || flush;
   assign up.ready = !skidV;
   assign inFire   = up.valid && !skidV;

   always_ff @(posedge clk) begin
      if (!rst_n || flush) st <= EMPTY;
      else                 st <= stNext;
   end

   always_comb begin
      stNext  = st;
      mainLd  = 1'b0;
      mainVIn = 1'b1;
      mainDIn = up.data;
      mainFIn = up.flags;
      skidLd  = 1'b0;
      skidVIn = 1'b1;
      skidDIn = up.data;
      skidFIn = up.flags;
      case (st)
         EMPTY: if (inFire) begin
            mainLd = 1'b1;
            stNext = ONE;
         end
         ONE: begin
            if (inFire && dn.ready) begin
               mainLd = 1'b1;
            end else if (inFire) begin
               skidLd = 1'b1;
               stNext = FULL;
            end else if (dn.ready) begin
               mainLd  = 1'b1;
               mainVIn = 1'b0;
               mainDIn = BUBBLE;
               mainFIn = '0;
               stNext  = EMPTY;
            end
         end
         FULL: if (dn.ready) begin
            // skid entry moves to head; skid slot empties so in_ready rises next cycle
            mainLd  = 1'b1;
            mainDIn = skidD;
            mainFIn = skidF;
            skidLd  = 1'b1;
            skidVIn = 1'b0;
            skidDIn = BUBBLE;
            skidFIn = '0;
            stNext  = ONE;
         end
         default: stNext = EMPTY;
      endcase
   end

   pipe_latch_reg #(.PAY_W(PAY_W), .FLAG_W(FLAG_W), .BUBBLE(BUBBLE)) uMain (
      .clk(clk), .clr(clr), .ld(mainLd), .vIn(mainVIn), .dIn(mainDIn), .fIn(mainFIn),
      .vOut(mainV), .dOut(mainD), .fOut(mainF)
   );

   pipe_latch_reg #(.PAY_W(PAY_W), .FLAG_W(FLAG_W), .BUBBLE(BUBBLE)) uSkid (
      .clk(clk), .clr(clr), .ld(skidLd), .vIn(skidVIn), .dIn(skidDIn), .fIn(skidFIn),
      .vOut(skidV), .dOut(skidD), .fOut(skidF)
   );

   assign dn.valid = mainV;
   assign dn.data  = mainD;
   assign dn.flags = mainF;

`ifdef PIPE_LATCH_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_stall_cnt <= '0;
         stat_flush_cnt <= '0;
      end else begin
         if (mainV && !dn.ready && stat_stall_cnt != '1)
            stat_stall_cnt <= stat_stall_cnt + CNT_W'(1);
         if (flush && stat_flush_cnt != '1)
            stat_flush_cnt <= stat_flush_cnt + CNT_W'(1);
      end
   end
`else
   assign stat_stall_cnt = '0;
   assign stat_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_latch.sv
// Self-checking bench for pipe_stage_latch against a queue-based reference model.
module tb_pipe_stage_latch;

   localparam int DATA_W     = 32;
   localparam int NUM_FIELDS = 3;
   localparam int INS_FIELD  = 2;
   localparam int FLAG_W     = 1;
   localparam logic [DATA_W-1:0] NOP = 32'h0000_0013;
   localparam int CNT_W      = 4;
   localparam int PAY_W      = DATA_W * NUM_FIELDS;
   localparam int SAT        = (1 << CNT_W) - 1;
`ifdef PIPE_LATCH_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   typedef struct {
      logic [PAY_W-1:0]  d;
      logic [FLAG_W-1:0] f;
   } ent_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;
   logic [CNT_W-1:0] statStall, statFlush;

   pipe_stage_latch_if #(.DATA_W(DATA_W), .NUM_FIELDS(NUM_FIELDS), .FLAG_W(FLAG_W)) upIf ();
   pipe_stage_latch_if #(.DATA_W(DATA_W), .NUM_FIELDS(NUM_FIELDS), .FLAG_W(FLAG_W)) dnIf ();

   pipe_stage_latch #(.DATA_W(DATA_W), .NUM_FIELDS(NUM_FIELDS), .INS_FIELD(INS_FIELD),
                      .FLAG_W(FLAG_W), .NOP_INSN(NOP), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .up(upIf.slave), .dn(dnIf.master),
      .stat_stall_cnt(statStall), .stat_flush_cnt(statFlush)
   );

   always #5 clk = ~clk;

   ent_t mq[$];
   int mStall = 0;
   int mFlush = 0;
   int nChecks = 0;
   int nFails = 0;

   function automatic logic [DATA_W-1:0] insOf(input logic [PAY_W-1:0] p);
      return p[INS_FIELD*DATA_W +: DATA_W];
   endfunction

   function automatic logic [PAY_W-1:0] mkPay(input logic [DATA_W-1:0] insn);
      logic [PAY_W-1:0] p;
      for (int k = 0; k < NUM_FIELDS; k++) p[k*DATA_W +: DATA_W] = $urandom;
      p[INS_FIELD*DATA_W +: DATA_W] = insn;
      return p;
   endfunction

   function automatic logic [CNT_W-1:0] expStall();
      return STATS ? CNT_W'(mStall) : '0;
   endfunction

   function automatic logic [CNT_W-1:0] expFlush();
      return STATS ? CNT_W'(mFlush) : '0;
   endfunction

   // Advance one clock; the model applies FIFO rules to the inputs seen at the edge.
   task automatic tick();
      ent_t e;
      bit inF, outF;
      @(posedge clk);
      inF  = upIf.valid && (mq.size() < 2);
      outF = (mq.size() > 0) && dnIf.ready;
      e.d  = upIf.data;
      e.f  = upIf.flags;
      if (!rst_n) begin
         mq.delete();
         mStall = 0;
         mFlush = 0;
      end else begin
         if (mq.size() > 0 && !dnIf.ready && mStall < SAT) mStall++;
         if (flush && mFlush < SAT) mFlush++;
         if (flush) mq.delete();
         else begin
            if (outF) void'(mq.pop_front());
            if (inF) mq.push_back(e);
         end
      end
      #1;
   endtask

   task automatic drive(input logic v, input logic [DATA_W-1:0] insn, input logic [FLAG_W-1:0] f);
      upIf.valid = v;
      upIf.data  = mkPay(insn);
      upIf.flags = f;
   endtask

   task automatic applyReset();
      rst_n = 1'b0; flush = 1'b0;
      drive(1'b1, 32'hdead, 1'b1);
      dnIf.ready = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      drive(1'b0, 32'h0, 1'b0);
   endtask

   task automatic test_reset();
      applyReset();
      nChecks++; if (dnIf.valid !== 1'b0) begin nFails++; $display("FAIL reset_valid got %b want 0", dnIf.valid); end
      nChecks++; if (upIf.ready !== 1'b1) begin nFails++; $display("FAIL reset_ready got %b want 1", upIf.ready); end
      nChecks++; if (insOf(dnIf.data) !== NOP) begin nFails++; $display("FAIL reset_ins got %h want %h", insOf(dnIf.data), NOP); end
      nChecks++; if (dnIf.data !== PAY_W'(NOP) << (INS_FIELD*DATA_W)) begin nFails++; $display("FAIL reset_bubble got %h", dnIf.data); end
      nChecks++; if (dnIf.flags !== '0) begin nFails++; $display("FAIL reset_flags got %b want 0", dnIf.flags); end
      nChecks++; if (statStall !== '0 || statFlush !== '0) begin nFails++; $display("FAIL reset_cnt got %0d/%0d want 0/0", statStall, statFlush); end
   endtask

   task automatic test_streaming();
      dnIf.ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, DATA_W'(i), 1'b0);
         tick();
         nChecks++; if (dnIf.valid !== 1'b1 || insOf(dnIf.data) !== DATA_W'(i)) begin
            nFails++; $display("FAIL stream_ins%0d got v=%b ins=%h want v=1 ins=%h", i, dnIf.valid, insOf(dnIf.data), i);
         end
         nChecks++; if (dnIf.data !== mq[0].d) begin nFails++; $display("FAIL stream_data%0d got %h want %h", i, dnIf.data, mq[0].d); end
      end
      drive(1'b0, 32'h0, 1'b0);
      tick();
      nChecks++; if (dnIf.valid !== 1'b0) begin nFails++; $display("FAIL stream_drain got %b want 0", dnIf.valid); end
   endtask

   task automatic test_back_pressure();
      logic [PAY_W-1:0] a;
      applyReset();
      dnIf.ready = 1'b0;
      drive(1'b1, 32'hA, 1'b0); a = upIf.data; tick();
      drive(1'b1, 32'hB, 1'b0); tick();
      drive(1'b1, 32'hC, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         nChecks++; if (upIf.ready !== 1'b0) begin nFails++; $display("FAIL bp_ready got %b want 0", upIf.ready); end
         nChecks++; if (dnIf.valid !== 1'b1 || dnIf.data !== a) begin nFails++; $display("FAIL bp_hold got %h want %h", dnIf.data, a); end
      end
      nChecks++; if (statStall !== (STATS ? CNT_W'(4) : CNT_W'(0))) begin nFails++; $display("FAIL bp_stall_cnt got %0d want %0d", statStall, STATS ? 4 : 0); end
      dnIf.ready = 1'b1;
      tick();
      nChecks++; if (insOf(dnIf.data) !== 32'hB || upIf.ready !== 1'b1) begin nFails++; $display("FAIL bp_B got ins=%h rdy=%b want B/1", insOf(dnIf.data), upIf.ready); end
      tick();
      drive(1'b0, 32'h0, 1'b0);
      nChecks++; if (insOf(dnIf.data) !== 32'hC || dnIf.valid !== 1'b1) begin nFails++; $display("FAIL bp_C got ins=%h v=%b want C/1", insOf(dnIf.data), dnIf.valid); end
      tick();
      nChecks++; if (dnIf.valid !== 1'b0) begin nFails++; $display("FAIL bp_empty got %b want 0", dnIf.valid); end
      nChecks++; if (statStall !== expStall()) begin nFails++; $display("FAIL bp_stall_final got %0d want %0d", statStall, expStall()); end
   endtask

   task automatic test_flush();
      applyReset();
      dnIf.ready = 1'b0;
      drive(1'b1, 32'h11, 1'b0); tick();
      drive(1'b1, 32'h22, 1'b0); tick();
      flush = 1'b1;
      drive(1'b1, 32'h33, 1'b1); tick();
      flush = 1'b0;
      drive(1'b0, 32'h0, 1'b0);
      nChecks++; if (dnIf.valid !== 1'b0) begin nFails++; $display("FAIL flush_valid got %b want 0", dnIf.valid); end
      nChecks++; if (insOf(dnIf.data) !== NOP) begin nFails++; $display("FAIL flush_ins got %h want %h", insOf(dnIf.data), NOP); end
      nChecks++; if (upIf.ready !== 1'b1) begin nFails++; $display("FAIL flush_ready got %b want 1", upIf.ready); end
      nChecks++; if (statFlush !== (STATS ? CNT_W'(1) : CNT_W'(0))) begin nFails++; $display("FAIL flush_cnt got %0d want %0d", statFlush, STATS ? 1 : 0); end
      dnIf.ready = 1'b1;
      tick();
      nChecks++; if (dnIf.valid !== 1'b0) begin nFails++; $display("FAIL flush_lost got %b want 0", dnIf.valid); end
      drive(1'b1, 32'h44, 1'b0); tick();
      flush = 1'b1;
      drive(1'b1, 32'h55, 1'b0); tick();
      flush = 1'b0;
      drive(1'b0, 32'h0, 1'b0);
      nChecks++; if (dnIf.valid !== 1'b0 || insOf(dnIf.data) !== NOP) begin nFails++; $display("FAIL flush_one got v=%b ins=%h want 0/%h", dnIf.valid, insOf(dnIf.data), NOP); end
      nChecks++; if (statFlush !== expFlush()) begin nFails++; $display("FAIL flush_cnt2 got %0d want %0d", statFlush, expFlush()); end
   endtask

   task automatic test_saturation();
      applyReset();
      dnIf.ready = 1'b0;
      drive(1'b1, 32'h66, 1'b0); tick();
      drive(1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 20; i++) tick();
      nChecks++; if (statStall !== (STATS ? CNT_W'(SAT) : CNT_W'(0))) begin nFails++; $display("FAIL sat_stall got %0d want %0d", statStall, STATS ? SAT : 0); end
      nChecks++; if (insOf(dnIf.data) !== 32'h66) begin nFails++; $display("FAIL sat_hold got %h want 66", insOf(dnIf.data)); end
   endtask

   task automatic test_flags();
      applyReset();
      dnIf.ready = 1'b0;
      drive(1'b1, 32'hA, 1'b1); tick();
      drive(1'b1, 32'hB, 1'b0); tick();
      drive(1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         tick();
         nChecks++; if (dnIf.flags !== 1'b1) begin nFails++; $display("FAIL flags_A got %b want 1", dnIf.flags); end
      end
      dnIf.ready = 1'b1;
      tick();
      nChecks++; if (dnIf.flags !== 1'b0 || insOf(dnIf.data) !== 32'hB) begin nFails++; $display("FAIL flags_B got f=%b ins=%h want 0/B", dnIf.flags, insOf(dnIf.data)); end
      tick();
   endtask

   task automatic test_random();
      applyReset();
      for (int c = 0; c < 400; c++) begin
         drive(1'($urandom_range(0, 3) != 0), $urandom, FLAG_W'($urandom_range(0, 1)));
         dnIf.ready = 1'($urandom_range(0, 2) != 0);
         flush = 1'($urandom_range(0, 24) == 0);
         tick();
         nChecks++; if (dnIf.valid !== (mq.size() > 0)) begin nFails++; $display("FAIL rnd_valid c=%0d got %b want %b", c, dnIf.valid, mq.size() > 0); end
         nChecks++; if (upIf.ready !== (mq.size() < 2)) begin nFails++; $display("FAIL rnd_ready c=%0d got %b want %b", c, upIf.ready, mq.size() < 2); end
         if (mq.size() > 0) begin
            nChecks++; if (dnIf.data !== mq[0].d || dnIf.flags !== mq[0].f) begin
               nFails++; $display("FAIL rnd_data c=%0d got %h/%b want %h/%b", c, dnIf.data, dnIf.flags, mq[0].d, mq[0].f);
            end
         end
         nChecks++; if (statStall !== expStall() || statFlush !== expFlush()) begin
            nFails++; $display("FAIL rnd_cnt c=%0d got %0d/%0d want %0d/%0d", c, statStall, statFlush, expStall(), expFlush());
         end
      end
      flush = 1'b0;
   endtask

   initial begin
      upIf.valid = 1'b0;
      upIf.data  = '0;
      upIf.flags = '0;
      dnIf.ready = 1'b0;
      test_reset();
      test_streaming();
      test_back_pressure();
      test_flush();
      test_saturation();
      test_flags();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
